frog_game_sequencer: RTL and testbench

Central game-flow controller for the frog/car game. It sequences the game through attract, play, hit, level-up and game-over phases, and generates the single car-movement tick whose period shortens with level. It also issues frog reset and enable commands and maintains the level and lives counters. It sits between the debounced buttons, the frog's collision/top-reached flags, the car instances and the level/7-segment logic.

---
 rtl/frog_game_sequencer.sv | 131 +++++++++++++
 tb/tb_frog_game_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_game_sequencer.sv
// Game-flow controller for the frog/car game: phase FSM,
// level/lives bookkeeping and the level-scaled car tick.
module frog_game_sequencer #(
  parameter logic [23:0] BASE_PERIOD = 24'd10000000,
  parameter logic [23:0] PERIOD_STEP = 24'd1000000,
  parameter logic [23:0] MIN_PERIOD  = 24'd2000000,
  parameter logic [23:0] HOLD_CYCLES = 24'd25000000,
  parameter logic [1:0]  LIVES_INIT  = 2'd3,
  parameter logic [3:0]  LEVEL_MAX   = 4'd9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Abort,
  input  logic       i_Collision,
  input  logic       i_Frog_At_Top,
  output logic       o_Car_Tick,
  output logic       o_Frog_Reset,
  output logic       o_Frog_Enable,
  output logic [3:0] o_Level,
  output logic [1:0] o_Lives,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    ATTRACT   = 3'd0,
    PLAY      = 3'd1,
    HIT       = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  level, level_nxt;
  logic [1:0]  lives, lives_nxt;
  logic [23:0] tick_cnt, hold_cnt;
  logic        frog_rst;
  logic        running, holding, hold_done, at_period;
  logic [3:0]  lvl_m1;
  logic [27:0] prod;
  logic [23:0] period;

  // Product is compared in 28 bits so large levels never wrap
  always_comb begin
    lvl_m1 = (level == 4'd0) ? 4'd0 : level - 4'd1;
    prod   = 28'(lvl_m1) * 28'(PERIOD_STEP);
    if (prod >= 28'(BASE_PERIOD - MIN_PERIOD))
      period = MIN_PERIOD;
    else
      period = BASE_PERIOD - prod[23:0];
  end

  assign running   = (state == ATTRACT) || (state == PLAY);
  assign holding   = (state == HIT) || (state == LEVEL_UP);
  assign hold_done = (hold_cnt == HOLD_CYCLES - 24'd1);
  assign at_period = (tick_cnt >= period - 24'd1);

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    lives_nxt = lives;
    if (i_Abort) begin
      state_nxt = ATTRACT;
      level_nxt = 4'd0;
      lives_nxt = 2'd0;
    end else begin
      unique case (state)
        ATTRACT, GAME_OVER: begin
          if (i_Start) begin
            state_nxt = PLAY;
            level_nxt = 4'd1;
            lives_nxt = LIVES_INIT;
          end
        end
        PLAY: begin
          if (i_Collision) begin
            state_nxt = HIT;
            lives_nxt = (lives == 2'd0) ? lives : lives - 2'd1;
          end else if (i_Frog_At_Top) begin
            state_nxt = LEVEL_UP;
            level_nxt = (level >= LEVEL_MAX) ? LEVEL_MAX
                                             : level + 4'd1;
          end
        end
        HIT: begin
          if (hold_done)
            state_nxt = (lives == 2'd0) ? GAME_OVER : PLAY;
        end
        LEVEL_UP: begin
          if (hold_done)
            state_nxt = PLAY;
        end
        default: state_nxt = ATTRACT;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= ATTRACT;
      level    <= 4'd0;
      lives    <= 2'd0;
      tick_cnt <= 24'd0;
      hold_cnt <= 24'd0;
      frog_rst <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      lives    <= lives_nxt;
      frog_rst <= (state_nxt == PLAY) && (state != PLAY);
      if (i_Abort || (state_nxt != state) || !running)
        tick_cnt <= 24'd0;
      else if (at_period)
        tick_cnt <= 24'd0;
      else
        tick_cnt <= tick_cnt + 24'd1;
      if (i_Abort || (state_nxt != state) || !holding)
        hold_cnt <= 24'd0;
      else
        hold_cnt <= hold_cnt + 24'd1;
    end
  end

  assign o_Car_Tick    = running && (tick_cnt == period - 24'd1);
  assign o_Frog_Reset  = frog_rst;
  assign o_Frog_Enable = (state == PLAY);
  assign o_Level       = level;
  assign o_Lives       = lives;
  assign o_State       = state;

endmodule

// File: tb/tb_frog_game_sequencer.sv
// Bench for frog_game_sequencer: directed scenarios plus
// random stimulus against a phase/cycle-count reference model.
module tb_frog_game_sequencer;

  localparam int BASE  = 10;
  localparam int STEP  = 2;
  localparam int MINP  = 4;
  localparam int HOLD  = 5;
  localparam int LIVES = 3;
  localparam int LMAX  = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       coll = 1'b0;
  logic       top = 1'b0;
  logic       tick, fr, en;
  logic [3:0] lvl;
  logic [1:0] lv;
  logic [2:0] st;

  int n_chk = 0;
  int n_fail = 0;

  int m_phase, m_level, m_lives, m_k;
  bit m_fr;

  frog_game_sequencer #(
    .BASE_PERIOD(24'd10),
    .PERIOD_STEP(24'd2),
    .MIN_PERIOD (24'd4),
    .HOLD_CYCLES(24'd5),
    .LIVES_INIT (2'd3),
    .LEVEL_MAX  (4'd9)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Start      (start),
    .i_Abort      (abort),
    .i_Collision  (coll),
    .i_Frog_At_Top(top),
    .o_Car_Tick   (tick),
    .o_Frog_Reset (fr),
    .o_Frog_Enable(en),
    .o_Level      (lvl),
    .o_Lives      (lv),
    .o_State      (st)
  );

  always #5 clk = ~clk;

  function automatic int period_of(input int level);
    int l = (level < 1) ? 1 : level;
    int p = BASE - (l - 1) * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  // m_k = 1-based count of cycles spent in the current phase
  function automatic logic [12:0] mdl_vec();
    bit tk = (m_phase <= 1) && (m_k % period_of(m_level) == 0);
    return {3'(m_phase), 4'(m_level), 2'(m_lives),
            tk, m_fr, (m_phase == 1)};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {st, lvl, lv, tick, fr, en};
  endfunction

  task automatic mdl_reset();
    m_phase = 0; m_level = 0; m_lives = 0;
    m_k = 1; m_fr = 0;
  endtask

  task automatic mdl_step(input bit s, a, c, t);
    int np = m_phase;
    m_fr = 0;
    if (a) begin
      np = 0; m_level = 0; m_lives = 0;
    end else begin
      case (m_phase)
        0, 4: if (s) begin
          np = 1; m_level = 1; m_lives = LIVES; m_fr = 1;
        end
        1: if (c) begin
          np = 2; m_lives = m_lives - 1;
        end else if (t) begin
          np = 3;
          m_level = (m_level + 1 > LMAX) ? LMAX : m_level + 1;
        end
        2: if (m_k == HOLD) begin
          np = (m_lives == 0) ? 4 : 1;
          m_fr = (np == 1);
        end
        3: if (m_k == HOLD) begin
          np = 1; m_fr = 1;
        end
        default: np = 0;
      endcase
    end
    if (a || np != m_phase) m_k = 1;
    else m_k = m_k + 1;
    m_phase = np;
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic cyc(input bit s, a, c, t);
    start = s; abort = a; coll = c; top = t;
    @(posedge clk);
    mdl_step(s, a, c, t);
    #1;
    start = 0; abort = 0; coll = 0; top = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs_vec() !== 13'h0) begin
      n_fail++;
      $display("FAIL reset: got %h want 0", obs_vec());
    end
    rst_n = 1;
    mdl_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL attract %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_start_ticks();
    cyc(1, 0, 0, 0);
    n_chk++;
    if ({st, fr, lvl, lv} !== {3'd1, 1'b1, 4'd1, 2'd3}) begin
      n_fail++;
      $display("FAIL start_entry: got %h want %h",
               {st, fr, lvl, lv}, {3'd1, 1'b1, 4'd1, 2'd3});
    end
    for (int i = 2; i <= 31; i++) begin
      cyc(0, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL start_tick cyc %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_level_up();
    for (int n = 0; n < 9; n++) begin
      cyc(0, 0, 0, 1);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL level_up %0d: got %h want %h",
                 n, obs_vec(), mdl_vec());
      end
      for (int i = 0; i < HOLD + 12; i++) begin
        cyc(0, 0, 0, 0);
        n_chk++;
        if (obs_vec() !== mdl_vec()) begin
          n_fail++;
          $display("FAIL level_run %0d/%0d: got %h want %h",
                   n, i, obs_vec(), mdl_vec());
        end
      end
    end
    n_chk++;
    if (lvl !== 4'd9) begin
      n_fail++;
      $display("FAIL level_sat: got %0d want 9", lvl);
    end
  endtask

  task automatic test_collision_priority();
    cyc(0, 0, 1, 1);
    n_chk++;
    if ({st, lv, lvl} !== {3'd2, 2'd2, 4'd9}) begin
      n_fail++;
      $display("FAIL coll_prio: got %h want %h",
               {st, lv, lvl}, {3'd2, 2'd2, 4'd9});
    end
    for (int i = 0; i < HOLD + 4; i++) begin
      cyc(0, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL hit_hold %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 40 && m_phase != 4; i++) begin
      cyc(0, 0, m_phase == 1, 0);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL to_over %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1);
      n_chk++;
      if (obs_vec() !== {3'd4, 4'd9, 2'd0, 3'b000}) begin
        n_fail++;
        $display("FAIL over_hold %0d: got %h want %h",
                 i, obs_vec(), {3'd4, 4'd9, 2'd0, 3'b000});
      end
    end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL restart %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_abort();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    n_chk++;
    if (obs_vec() !== 13'h0) begin
      n_fail++;
      $display("FAIL abort_hit: got %h want 0", obs_vec());
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL abort_ticks %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
    end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 40 && m_phase != 4; i++)
      cyc(0, 0, m_phase == 1, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL abort_over %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    n_chk++;
    if (obs_vec() !== 13'h0) begin
      n_fail++;
      $display("FAIL async_rst: got %h want 0", obs_vec());
    end
    mdl_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    mdl_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL attract_ign %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    bit s, a, c, t;
    for (int i = 0; i < 2000; i++) begin
      s = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 9) == 0);
      cyc(s, a, c, t);
      n_chk++;
      if (obs_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL random %0d: got %h want %h",
                 i, obs_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start_ticks();
    test_level_up();
    test_collision_priority();
    test_game_over();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
